// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline <-> hazard/exception controller bundle.
//   master: pipeline side, drives requests and consumes stall/flush/new_pc/mc status
//   slave : controller side, the mirror image
//   stallreq_id  load-use hazard request from ID
//   mc_start     one-cycle pulse from EX starting a multi-cycle op
//   excpt_req    redirect request from MEM, excpt_pc its target
//   stall[5:0]   per-stage hold: pc, if_id, id, id_ex, ex_mem, mem_wb
//   flush/new_pc pipeline clear and PC to load
//   mc_busy/mc_done multi-cycle op status, stall_cnt stalled-cycle counter
interface pipe_ctrl_if #(parameter int PERF_W = 16);
  logic              stallreq_id;
  logic              mc_start;
  logic              excpt_req;
  logic [31:0]       excpt_pc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_busy;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cnt;
  modport master (
    output stallreq_id, mc_start, excpt_req, excpt_pc,
    input  stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );
  modport slave (
    input  stallreq_id, mc_start, excpt_req, excpt_pc,
    output stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with multi-cycle EX sequencing.
//   clk  rising-edge clock
//   rst  synchronous reset, active low
//   bus  pipe_ctrl_if.slave: hazard/mc/exception requests in; stall, flush,
//        new_pc, mc_busy, mc_done, stall_cnt out
//   MC_LAT  EX busy cycles of a multi-cycle op (2..63)
//   PERF_W  width of the stalled-cycle counter
module pipe_ctrl #(
  parameter int MC_LAT = 32,
  parameter int PERF_W = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;
  localparam logic [1:0] FLUSH   = 2'd3;
  logic [1:0]        state, state_nx;
  logic [5:0]        cnt;
  logic [31:0]       pc_q;
  logic [PERF_W-1:0] perf_q;
  logic [5:0]        stall;
  // excpt_req outranks everything except an ongoing FLUSH, which always returns to RUN
  always_comb begin
    state_nx = state == RUN     ? (bus.excpt_req ? FLUSH : bus.mc_start ? MC_BUSY : RUN) :
               state == MC_BUSY ? (bus.excpt_req ? FLUSH : cnt == 6'd0 ? MC_DONE : MC_BUSY) :
               state == MC_DONE ? (bus.excpt_req ? FLUSH : RUN) :
               RUN;
  end
  // reset forces the hold off even before the state register settles
  always_comb begin
    stall = !rst                               ? 6'b000000 :
            state == MC_BUSY                   ? 6'b001111 :
            state == RUN && bus.stallreq_id    ? 6'b000111 :
            6'b000000;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      cnt    <= '0;
      pc_q   <= '0;
      perf_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= state == RUN && state_nx == MC_BUSY ? 6'(MC_LAT - 1) :
                state == MC_BUSY && cnt != 6'd0    ? cnt - 6'd1 : cnt;
      pc_q   <= state_nx == FLUSH ? bus.excpt_pc : pc_q;
      perf_q <= |stall && !(&perf_q) ? perf_q + 1'b1 : perf_q;
    end
  end
  assign bus.stall     = stall;
  assign bus.flush     = state == FLUSH;
  assign bus.new_pc    = pc_q;
  assign bus.mc_busy   = state == MC_BUSY;
  assign bus.mc_done   = state == MC_DONE;
  assign bus.stall_cnt = perf_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (MC_LAT=4, PERF_W=4).
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  pipe_ctrl_if #(.PERF_W(4)) bus ();
  pipe_ctrl #(.MC_LAT(4), .PERF_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic set_in(input logic s, input logic m, input logic e, input logic [31:0] pc);
    bus.stallreq_id = s;
    bus.mc_start    = m;
    bus.excpt_req   = e;
    bus.excpt_pc    = pc;
  endtask
  initial begin
    // reset held two edges with every input high
    rst = 1'b0;
    set_in(1, 1, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      cyc(); mid();
      chk("rst_stall", bus.stall, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_new_pc", bus.new_pc, 0);
      chk("rst_mc_busy", bus.mc_busy, 0);
      chk("rst_mc_done", bus.mc_done, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
    end
    cyc();
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    mid();
    chk("run_stall", bus.stall, 0);
    chk("run_busy", bus.mc_busy, 0);
    cyc(); mid();
    chk("run_flush", bus.flush, 0);
    chk("run_cnt", bus.stall_cnt, 0);
    // load-use stall for three cycles
    cyc();
    bus.stallreq_id = 1;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("lu_stall", bus.stall, 6'b000111); cyc();
    end
    bus.stallreq_id = 0;
    mid();
    chk("lu_stall_off", bus.stall, 0);
    chk("lu_cnt", bus.stall_cnt, 3);
    // multi-cycle op from a fresh reset
    cyc(); rst = 1'b0; cyc(); rst = 1'b1;
    bus.mc_start = 1;
    mid(); chk("mc_start_stall", bus.stall, 0);
    cyc(); bus.mc_start = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("mc_busy", bus.mc_busy, 1);
      chk("mc_stall", bus.stall, 6'b001111);
      chk("mc_no_done", bus.mc_done, 0);
      bus.mc_start = 1;  // ignored outside RUN
      cyc();
      bus.mc_start = 0;
    end
    bus.stallreq_id = 1;  // masked in MC_DONE
    mid();
    chk("mc_done", bus.mc_done, 1);
    chk("mc_done_busy", bus.mc_busy, 0);
    chk("mc_done_stall", bus.stall, 0);
    cyc(); bus.stallreq_id = 0;
    mid();
    chk("mc_back_run", bus.mc_done, 0);
    chk("mc_back_busy", bus.mc_busy, 0);
    chk("mc_cnt", bus.stall_cnt, 4);
    // exception redirect from RUN
    cyc();
    set_in(0, 0, 1, 32'hBFC0_0380);
    mid(); chk("ex_pre_flush", bus.flush, 0);
    cyc();
    set_in(1, 0, 1, 32'h1234_5678);  // both ignored during FLUSH
    mid();
    chk("ex_flush", bus.flush, 1);
    chk("ex_new_pc", bus.new_pc, 32'hBFC0_0380);
    chk("ex_flush_stall", bus.stall, 0);
    cyc();
    set_in(0, 0, 0, 0);
    mid();
    chk("ex_flush_off", bus.flush, 0);
    chk("ex_pc_hold", bus.new_pc, 32'hBFC0_0380);
    // exception aborts multi-cycle op in its 2nd busy cycle
    cyc(); bus.mc_start = 1;
    cyc(); bus.mc_start = 0;
    mid(); chk("ab_busy1", bus.mc_busy, 1);
    cyc(); set_in(0, 0, 1, 32'h8000_0180);
    mid(); chk("ab_busy2", bus.mc_busy, 1);
    cyc(); set_in(0, 0, 0, 0);
    mid();
    chk("ab_flush", bus.flush, 1);
    chk("ab_busy_off", bus.mc_busy, 0);
    chk("ab_no_done", bus.mc_done, 0);
    chk("ab_new_pc", bus.new_pc, 32'h8000_0180);
    for (int i = 0; i < 5; i++) begin
      cyc(); mid();
      chk("ab_no_done_later", bus.mc_done, 0);
      chk("ab_no_busy_later", bus.mc_busy, 0);
    end
    // mc_start with stallreq_id, then reset mid-op
    cyc(); set_in(1, 1, 0, 0);
    mid(); chk("both_stall", bus.stall, 6'b000111);
    cyc(); set_in(0, 0, 0, 0);
    mid(); chk("both_busy", bus.mc_busy, 1);
    cyc(); rst = 1'b0;
    set_in(1, 1, 1, 32'hDEAD_BEEF);
    mid(); chk("rmid_stall", bus.stall, 0);
    cyc(); rst = 1'b1;
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("rmid_no_done", bus.mc_done, 0);
      chk("rmid_no_flush", bus.flush, 0);
      chk("rmid_no_busy", bus.mc_busy, 0);
      cyc();
    end
    chk("rmid_pc", bus.new_pc, 0);
    // saturation of the 4-bit counter
    rst = 1'b0; cyc(); rst = 1'b1;
    bus.stallreq_id = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 13) chk("sat_14", bus.stall_cnt, 14);
    end
    bus.stallreq_id = 0;
    mid();
    chk("sat_15", bus.stall_cnt, 15);
    cyc(); cyc(); mid();
    chk("sat_hold", bus.stall_cnt, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
